resp_framer: RTL and testbench

//  Transmit-side counterpart of the command parser. Queues response records
//  (opcode + up to 4 payload bytes) from the command/glitch logic.

---
 rtl/resp_framer.sv | 108 ++++++++++
 tb/tb_resp_framer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/resp_framer.sv
// resp_framer: queues response records and frames them as SYNC, OPCODE, LEN, PAYLOAD, CHK into uart_tx
module resp_framer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         MAX_LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [7:0]  i_opcode,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_data,
  output logic        o_req_ready,
  output logic        o_tx_strobe,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t      r_state;
  logic [7:0]  r_fop  [FIFO_DEPTH];
  logic [2:0]  r_flen [FIFO_DEPTH];
  logic [31:0] r_fdat [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [7:0]  r_wop, r_chk, r_byte;
  logic [2:0]  r_wlen, r_idx;
  logic [31:0] r_wdat;
  logic        r_stb, r_ovf, r_rdy;
  logic [AW:0] w_cnt;
  logic        w_full, w_empty, w_push;
  logic [2:0]  w_clen, w_last, w_n;
  logic [1:0]  w_pi;
  logic [7:0]  w_pay, w_fbyte;
  assign w_cnt   = r_wp - r_rp;
  assign w_full  = w_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_empty = w_cnt == '0;
  assign w_push  = i_req & ~w_full;
  assign w_clen  = (i_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : i_len;
  // w_n is the index of the byte about to be strobed; CHK sits right after the payload
  assign w_last  = 3'd3 + r_wlen;
  assign w_n     = r_idx + 3'd1;
  assign w_pi    = 2'(w_n - 3'd3);
  assign w_pay   = r_wdat[{w_pi, 3'b000} +: 8];
  assign w_fbyte = (w_n == 3'd1) ? r_wop :
                   (w_n == 3'd2) ? {5'b0, r_wlen} :
                   (w_n == w_last) ? r_chk : w_pay;
  assign o_req_ready = r_rdy & ~w_full;
  assign o_tx_strobe = r_stb;
  assign o_tx_byte   = r_byte;
  assign o_overflow  = r_ovf;
  assign o_busy      = ~w_empty | (r_state != IDLE);
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fop[r_wp[AW-1:0]]  <= i_opcode;
      r_flen[r_wp[AW-1:0]] <= w_clen;
      r_fdat[r_wp[AW-1:0]] <= i_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_wop   <= '0;
      r_wlen  <= '0;
      r_wdat  <= '0;
      r_idx   <= '0;
      r_chk   <= '0;
      r_byte  <= '0;
      r_stb   <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      r_ovf <= i_req & w_full;
      r_stb <= 1'b0;
      if (w_push) r_wp <= r_wp + 1'b1;
      case (r_state)
        IDLE: if (!w_empty) r_state <= LOAD;
        LOAD: begin
          r_wop   <= r_fop[r_rp[AW-1:0]];
          r_wlen  <= r_flen[r_rp[AW-1:0]];
          r_wdat  <= r_fdat[r_rp[AW-1:0]];
          r_rp    <= r_rp + 1'b1;
          r_idx   <= '0;
          r_chk   <= '0;
          r_byte  <= SYNC_BYTE;
          r_stb   <= 1'b1;
          r_state <= SEND;
        end
        SEND: r_state <= WAIT;
        WAIT: begin
          if (i_tx_done && r_idx == w_last) r_state <= IDLE;
          else if (i_tx_done) begin
            r_idx   <= w_n;
            r_byte  <= w_fbyte;
            r_stb   <= 1'b1;
            r_chk   <= (w_n == w_last) ? r_chk : r_chk ^ w_fbyte;
            r_state <= SEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_resp_framer.sv
// tb_resp_framer: directed frames against hand-computed byte lists, with a one-cycle uart_tx done model
module tb_resp_framer;
  logic        clk = 1'b0, reset = 1'b1, i_req = 1'b0;
  logic [7:0]  i_opcode = '0;
  logic [2:0]  i_len = '0;
  logic [31:0] i_data = '0;
  logic        o_req_ready, o_tx_strobe, o_busy, o_overflow, i_tx_done;
  logic [7:0]  o_tx_byte;
  logic        man_done = 1'b0, model_done = 1'b0;
  bit          auto_done = 1'b0, outst = 1'b0;
  int          n_tot = 0, n_bad = 0, cnt = 0, cyc = 0, viol = 0, ovf_cnt = 0;
  logic [7:0]  cap[$];
  int          st[$];
  always #5 clk = ~clk;
  assign i_tx_done = man_done | model_done;
  resp_framer dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_opcode(i_opcode), .i_len(i_len),
    .i_data(i_data), .o_req_ready(o_req_ready), .o_tx_strobe(o_tx_strobe),
    .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_overflow(o_overflow)
  );
  // uart_tx stand-in: done one cycle after each strobe while auto_done is set
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      outst = 1'b0;
      cnt = 0;
      model_done = 1'b0;
    end else begin
      if (model_done) model_done = 1'b0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          outst = 1'b0;
        end
      end
      if (o_tx_strobe) begin
        if (outst) viol++;
        outst = 1'b1;
        cap.push_back(o_tx_byte);
        st.push_back(cyc);
        cnt = auto_done ? 1 : 0;
      end else if (auto_done && outst && cnt == 0 && !model_done) cnt = 1;
      if (o_overflow) ovf_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] op, input logic [2:0] len, input logic [31:0] d);
    @(posedge clk);
    #1 i_req = 1'b1; i_opcode = op; i_len = len; i_data = d;
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask
  task automatic wait_n(input int n);
    int k = 0;
    while (cap.size() < n && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_bytes", 32'(cap.size()), 32'(n));
  endtask
  task automatic cmp_bytes(input string tag, input int base, input logic [7:0] e[$]);
    foreach (e[i])
      chk($sformatf("%s_b%0d", tag, i), (base + i < cap.size()) ? 32'(cap[base+i]) : 32'hDEAD, 32'(e[i]));
  endtask
  task automatic quiet(input string tag, input int n);
    repeat (20) @(negedge clk);
    #1 chk(tag, 32'(cap.size()), 32'(n));
  endtask
  initial begin
    int b, k;
    logic [7:0] e[$];
    repeat (3) @(negedge clk);
    chk("rst_strobe", o_tx_strobe, 0);
    chk("rst_byte", o_tx_byte, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ready", o_req_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("ready_after_rst", o_req_ready, 1);
    chk("idle_busy", o_busy, 0);
    // single record, latency and busy fall
    auto_done = 1'b1;
    b = cap.size();
    push(8'h10, 3'd2, 32'h0000BEEF);
    @(negedge clk); chk("t1_lat_c1", o_tx_strobe, 0);
    @(negedge clk); chk("t1_lat_c2", o_tx_strobe, 0);
    @(negedge clk); chk("t1_lat_stb", o_tx_strobe, 1);
    chk("t1_lat_sync", o_tx_byte, 8'hA5);
    wait_n(b + 6);
    e = '{8'hA5, 8'h10, 8'h02, 8'hEF, 8'hBE, 8'h43};
    cmp_bytes("t1", b, e);
    k = 0;
    while (!model_done && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t1_busy_at_done", o_busy, 1);
    @(negedge clk);
    #1 chk("t1_busy_fall", o_busy, 0);
    chk("t1_byte_held", o_tx_byte, 8'h43);
    quiet("t1_count", b + 6);
    // empty payload
    b = cap.size();
    push(8'h01, 3'd0, 32'h0);
    wait_n(b + 4);
    e = '{8'hA5, 8'h01, 8'h00, 8'h01};
    cmp_bytes("t2", b, e);
    quiet("t2_count", b + 4);
    // fill the queue behind a stalled frame
    auto_done = 1'b0;
    b = cap.size();
    push(8'h01, 3'd1, 32'h01);
    repeat (4) @(posedge clk);
    for (int i = 2; i <= 4; i++) push(8'(i), 3'd1, 32'(i));
    chk("t3_ready_3q", o_req_ready, 1);
    push(8'h05, 3'd1, 32'h05);
    chk("t3_ready_full", o_req_ready, 0);
    chk("t3_ovf_none", o_overflow, 0);
    push(8'h06, 3'd1, 32'h06);
    chk("t3_ovf_pulse", o_overflow, 1);
    @(posedge clk);
    #1 chk("t3_ovf_clear", o_overflow, 0);
    auto_done = 1'b1;
    wait_n(b + 25);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_op%0d", i), (b + 5*i + 4 < cap.size()) ? 32'(cap[b+5*i+1]) : 32'hDEAD, 32'(i + 1));
      chk($sformatf("t3_chk%0d", i), (b + 5*i + 4 < cap.size()) ? 32'(cap[b+5*i+4]) : 32'hDEAD, 32'h01);
    end
    quiet("t3_count", b + 25);
    chk("t3_ovf_cnt", 32'(ovf_cnt), 1);
    // length clamp
    b = cap.size();
    push(8'h22, 3'd7, 32'h11223344);
    wait_n(b + 8);
    e = '{8'hA5, 8'h22, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11, 8'h62};
    cmp_bytes("t4", b, e);
    quiet("t4_count", b + 8);
    // back-to-back records with a fast uart_tx
    b = cap.size();
    push(8'h41, 3'd1, 32'h5A);
    push(8'h42, 3'd0, 32'h0);
    wait_n(b + 9);
    e = '{8'hA5, 8'h41, 8'h01, 8'h5A, 8'h1A, 8'hA5, 8'h42, 8'h00, 8'h42};
    cmp_bytes("t6", b, e);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_gap%0d", i), (b + 8 < st.size()) ? 32'(st[b+i+1] - st[b+i]) : 32'hDEAD, (i == 4) ? 32'd4 : 32'd2);
    quiet("t6_count", b + 9);
    // reset during the first payload byte
    b = cap.size();
    push(8'h55, 3'd2, 32'h0102);
    wait_n(b + 4);
    chk("t5_pre_stb", o_tx_strobe, 1);
    reset = 1'b1;
    #1 chk("t5_rst_stb", o_tx_strobe, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_ready", o_req_ready, 0);
    auto_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("t5_ready_back", o_req_ready, 1);
    man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    quiet("t5_stray", b + 4);
    chk("t5_busy_idle", o_busy, 0);
    auto_done = 1'b1;
    b = cap.size();
    push(8'h30, 3'd0, 32'h0);
    wait_n(b + 4);
    e = '{8'hA5, 8'h30, 8'h00, 8'h30};
    cmp_bytes("t5", b, e);
    quiet("t5_count", b + 4);
    chk("no_strobe_outstanding", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
